// File: rtl/filter_sequencer_pkg.sv
// Shared types and defaults for the filter sequencing chain.
// Build option FILTER_BYPASS_EN is consumed by filter_sequencer, not here.
package kf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILT = 2'd1,
    SEND = 2'd2
  } seq_state_t;

  localparam int KF_DATA_W      = 16;
  localparam int KF_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/filter_sequencer_if.sv
// Sample/filter/transmit handshake bundle; master = sequencer, slave = surrounding chain.
interface filter_sequencer_if #(
  parameter int DATA_W = kf_pkg::KF_DATA_W
);

  logic              z_valid;
  logic [DATA_W-1:0] z_in;
  logic              kf_start;
  logic [DATA_W-1:0] kf_z;
  logic              kf_done;
  logic [DATA_W-1:0] kf_x;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;

  modport master (
    input  z_valid, z_in, kf_done, kf_x, tx_busy,
    output kf_start, kf_z, tx_start, tx_data
  );

  modport slave (
    output z_valid, z_in, kf_done, kf_x, tx_busy,
    input  kf_start, kf_z, tx_start, tx_data
  );

endinterface

// File: rtl/filter_sequencer_sync_edge_detect.sv
// Two-flop synchronizer plus history flop; pulse is high for one cycle per rising edge.
// Pulse appears after the 2nd clk edge that has captured the input high.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign pulse = sync2 & ~hist;

endmodule

// File: rtl/filter_sequencer.sv
// Sequences one sample through deserializer -> Kalman filter -> serializer, counting drops and timeouts.
// Optional FILTER_BYPASS_EN: skip the filter and send the measurement straight to the serializer.
module filter_sequencer
  import kf_pkg::*;
#(
  parameter int DATA_W      = KF_DATA_W,
  parameter int TIMEOUT_CYC = KF_TIMEOUT_DEF,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clr_err,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      overrun_cnt,
  filter_sequencer_if.master    bus
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  seq_state_t    state;
  logic [TW-1:0] tcnt;
  logic          samp;
  logic          to_fire;
  logic          overrun;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.z_valid),
    .pulse    (samp)
  );

`ifdef FILTER_BYPASS_EN
  assign to_fire = 1'b0;
`else
  // kf_done in the final cycle takes priority over the abort
  assign to_fire = (state == FILT) && !bus.kf_done && (tcnt == T_LAST);
`endif
  assign overrun = samp && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tcnt         <= '0;
      busy         <= 1'b0;
      bus.kf_start <= 1'b0;
      bus.kf_z     <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
    end else begin
      bus.kf_start <= 1'b0;
      bus.tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (samp && enable) begin
`ifdef FILTER_BYPASS_EN
            bus.tx_data  <= bus.z_in;
            state        <= SEND;
`else
            bus.kf_z     <= bus.z_in;
            bus.kf_start <= 1'b1;
            tcnt         <= '0;
            state        <= FILT;
`endif
            busy         <= 1'b1;
          end
        end
`ifndef FILTER_BYPASS_EN
        FILT: begin
          if (bus.kf_done) begin
            bus.tx_data <= bus.kf_x;
            state       <= SEND;
          end else if (to_fire) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
`endif
        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Status flags: a set/increment in the same cycle as clr_err wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (to_fire)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

      if (overrun) begin
        if (clr_err)                     overrun_cnt <= CNT_W'(1);
        else if (overrun_cnt != CNT_MAX) overrun_cnt <= overrun_cnt + CNT_W'(1);
      end else if (clr_err) begin
        overrun_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer (TIMEOUT_CYC=16, CNT_W=2); FILTER_BYPASS_EN selects the bypass checks.
module tb_filter_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clr_err;
  logic       busy;
  logic       timeout_err;
  logic [1:0] overrun_cnt;

  int checks = 0;
  int errors = 0;
  int kf_start_cnt = 0;
  int tx_start_cnt = 0;
  int lat;

  filter_sequencer_if #(.DATA_W(16)) bus ();

  filter_sequencer #(
    .DATA_W      (16),
    .TIMEOUT_CYC (16),
    .CNT_W       (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clr_err     (clr_err),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_cnt (overrun_cnt),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // pulse counters: a pulse is counted once per edge it is seen high
  always @(posedge clk) begin
    if (bus.kf_start === 1'b1) kf_start_cnt++;
    if (bus.tx_start === 1'b1) tx_start_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_sample(input logic [15:0] z, output int latency);
    latency = 99;
    bus.z_in    = z;
    bus.z_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.kf_start === 1'b1) begin
        latency = i;
        break;
      end
    end
    bus.z_valid = 1'b0;
    chk("kf_start_latency", (latency >= 2 && latency <= 4), 1);
  endtask

  task automatic pulse_kf(input logic [15:0] x);
    bus.kf_done = 1'b1;
    bus.kf_x    = x;
    tick();
    bus.kf_done = 1'b0;
  endtask

  task automatic extra_pulse();
    bus.z_valid = 1'b1;
    tick();
    bus.z_valid = 1'b0;
    ticks(2);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    clr_err     = 1'b0;
    bus.z_valid = 1'b0;
    bus.z_in    = '0;
    bus.kf_done = 1'b0;
    bus.kf_x    = '0;
    bus.tx_busy = 1'b0;

    ticks(3);
    chk("rst_kf_start", bus.kf_start, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overrun_cnt", overrun_cnt, 0);
    chk("rst_kf_z", bus.kf_z, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    ticks(2);

`ifdef FILTER_BYPASS_EN
    bus.z_in    = 16'hBEEF;
    bus.z_valid = 1'b1;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (busy === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.z_valid = 1'b0;
    chk("byp_latency", (lat >= 2 && lat <= 4), 1);
    chk("byp_tx_data", bus.tx_data, 16'hBEEF);
    tick();
    chk("byp_tx_start", bus.tx_start, 1);
    tick();
    chk("byp_tx_start_low", bus.tx_start, 0);
    chk("byp_busy_done", busy, 0);
    chk("byp_kf_start_cnt", kf_start_cnt, 0);
    chk("byp_tx_start_cnt", tx_start_cnt, 1);
    chk("byp_timeout_err", timeout_err, 0);
`else
    // nominal transaction with a 10-cycle filter
    start_sample(16'h1234, lat);
    chk("nom_kf_z", bus.kf_z, 16'h1234);
    chk("nom_busy", busy, 1);
    ticks(9);
    pulse_kf(16'h1200);
    chk("nom_tx_data", bus.tx_data, 16'h1200);
    chk("nom_tx_start_early", bus.tx_start, 0);
    tick();
    chk("nom_tx_start", bus.tx_start, 1);
    tick();
    chk("nom_tx_start_low", bus.tx_start, 0);
    chk("nom_busy_done", busy, 0);
    chk("nom_kf_start_cnt", kf_start_cnt, 1);
    chk("nom_tx_start_cnt", tx_start_cnt, 1);

    // three dropped samples while filtering
    start_sample(16'h1111, lat);
    ticks(2);
    bus.z_in = 16'hDEAD;
    extra_pulse();
    extra_pulse();
    extra_pulse();
    tick();
    chk("ovr_cnt", overrun_cnt, 3);
    chk("ovr_kf_z_kept", bus.kf_z, 16'h1111);
    chk("ovr_busy", busy, 1);
    pulse_kf(16'h2222);
    chk("ovr_tx_data", bus.tx_data, 16'h2222);
    ticks(2);
    chk("ovr_kf_start_cnt", kf_start_cnt, 2);
    chk("ovr_tx_start_cnt", tx_start_cnt, 2);

    // back-pressure with saturating drops while waiting in SEND
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_overrun", overrun_cnt, 0);
    bus.tx_busy = 1'b1;
    start_sample(16'h3333, lat);
    ticks(2);
    pulse_kf(16'h4444);
    ticks(2);
    for (int i = 0; i < 5; i++) extra_pulse();
    ticks(2);
    chk("sat_cnt", overrun_cnt, 3);
    chk("bp_no_tx_start", tx_start_cnt, 2);
    ticks(30);
    chk("bp_busy", busy, 1);
    chk("bp_tx_start_held", bus.tx_start, 0);
    bus.tx_busy = 1'b0;
    tick();
    chk("bp_tx_start", bus.tx_start, 1);
    tick();
    chk("bp_tx_start_low", bus.tx_start, 0);
    chk("bp_tx_data", bus.tx_data, 16'h4444);
    chk("bp_tx_start_cnt", tx_start_cnt, 3);

    // timeout: error exactly 16 cycles after kf_start, set beats clear
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    start_sample(16'h5555, lat);
    ticks(15);
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy_before", busy, 1);
    clr_err = 1'b1;
    tick();
    chk("to_set_wins", timeout_err, 1);
    chk("to_busy_after", busy, 0);
    tick();
    clr_err = 1'b0;
    chk("to_cleared", timeout_err, 0);
    ticks(2);
    chk("to_no_tx_start", tx_start_cnt, 3);

    // kf_done in the last allowed cycle
    start_sample(16'h6666, lat);
    ticks(15);
    pulse_kf(16'h7777);
    chk("last_no_error", timeout_err, 0);
    chk("last_tx_data", bus.tx_data, 16'h7777);
    chk("last_busy", busy, 1);
    tick();
    chk("last_tx_start", bus.tx_start, 1);
    tick();
    chk("last_tx_start_cnt", tx_start_cnt, 4);

    // samples ignored while disabled
    enable      = 1'b0;
    bus.z_in    = 16'h8888;
    bus.z_valid = 1'b1;
    ticks(2);
    bus.z_valid = 1'b0;
    ticks(4);
    chk("dis_busy", busy, 0);
    chk("dis_kf_start_cnt", kf_start_cnt, 5);
    chk("dis_overrun", overrun_cnt, 0);
    chk("dis_kf_z", bus.kf_z, 16'h6666);

    // reset while filtering
    enable = 1'b1;
    start_sample(16'h9999, lat);
    ticks(3);
    rst_n = 1'b0;
    #1;
    chk("mrst_kf_z", bus.kf_z, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_kf_start", bus.kf_start, 0);
    chk("mrst_tx_data", bus.tx_data, 0);
    tick();
    rst_n = 1'b1;
    ticks(2);
    pulse_kf(16'hAAAA);
    ticks(3);
    chk("mrst_idle", busy, 0);
    chk("mrst_no_tx", tx_start_cnt, 4);
    chk("mrst_tx_data_kept", bus.tx_data, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_sequencer.md
# filter_sequencer

Single-clock controller that sequences one sample at a time through the processing chain: deserializer → Kalman filter → serializer. It synchronizes the deserializer's `data_ready` strobe, latches the 16-bit measurement, and starts the filter with a start/done handshake. It then hands the estimate to the parallel-to-serial transmitter once that transmitter is idle. Dropped samples and filter timeouts are counted and flagged for status LEDs and debug.

## Interface
- `DATA_W`, 16, sample/estimate width
- `TIMEOUT_CYC`, 1024, max `clk` cycles in FILT before abort (≥2)
- `CNT_W`, 8, overrun counter width
- `clk` in 1: system clock; the only clock
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: accept new samples when high
- `z_valid` in 1: deserializer data-ready, asynchronous to `clk`
- `z_in` in DATA_W: deserializer parallel word, stable while `z_valid` high
- `kf_start` out 1: one-cycle filter start pulse
- `kf_z` out DATA_W: latched measurement to filter
- `kf_done` in 1: one-cycle filter completion pulse
- `kf_x` in DATA_W: filter estimate, valid with `kf_done`
- `tx_start` out 1: one-cycle transmit start pulse
- `tx_data` out DATA_W: word to serializer, held until next load
- `tx_busy` in 1: serializer shifting
- `busy` out 1: state ≠ IDLE
- `clr_err` in 1: clears `timeout_err` and `overrun_cnt`
- `timeout_err` out 1: sticky filter-timeout flag
- `overrun_cnt` out CNT_W: saturating dropped-sample count

## Operation
- `z_valid` passes through a 2-flop synchronizer plus a history flop; `samp` = sync2 & ~hist.
- All synchronizer flops reset to 0. A `z_valid` held high across reset release counts as one sample.
- States: IDLE, FILT, SEND.
  - IDLE: on `samp & enable`, latch `z_in`→`kf_z`, pulse `kf_start`, clear the timeout counter, go to FILT. `samp & ~enable` is ignored and not counted.
  - FILT: the timeout counter increments each cycle.
    - On `kf_done`, latch `kf_x`→`tx_data` and go to SEND.
    - Otherwise, when the count reaches TIMEOUT_CYC−1, set `timeout_err` and go to IDLE. No transmit occurs.
  - SEND: when `tx_busy`=0, pulse `tx_start` and go to IDLE. Otherwise wait; there is no timeout.
- `samp` in FILT or SEND increments `overrun_cnt` (saturates at 2^CNT_W−1). The sample is dropped and the in-flight sample is unaffected.
- `enable` falling mid-transaction does not abort the transaction; it only gates new samples.
- Simultaneous events:
  - `kf_done` and timeout in the same cycle: `kf_done` wins.
  - Set and `clr_err` in the same cycle: set/increment wins (`timeout_err`=1, `overrun_cnt`=1).
- Reset mid-operation: returns to IDLE immediately. Pending transaction discarded; no pulse emitted.

## Timing
- Reset values: `kf_start`=0, `tx_start`=0, `busy`=0, `timeout_err`=0, `overrun_cnt`=0, `kf_z`=0, `tx_data`=0.
- `z_valid` rise to `kf_start`: `kf_start` is high in the cycle after the 2nd `clk` edge that samples `z_valid` high (3 edges through sync + edge register). Accept ±1 cycle of synchronizer uncertainty in test.
- `kf_done` at edge N → `tx_data` valid after edge N. `tx_start` high in cycle N+1 if `tx_busy`=0.
- Minimum IDLE→IDLE transaction: 3 cycles plus filter latency.
- All outputs are registered. Pulses are exactly one cycle.

## Configuration
- `FILTER_BYPASS_EN` defined: FILT state is not built. In IDLE, `samp & enable` latches `z_in` directly into `tx_data` and goes to SEND. `kf_start` is tied 0, and `kf_done`/`kf_x` are unused. `timeout_err` is held 0.
- Undefined: full sequencing as above.

## Structure
- Shared package `kf_pkg`:
  - `seq_state_t` enum {IDLE, FILT, SEND}
  - `KF_DATA_W`=16 default
  - `KF_TIMEOUT_DEF`=1024
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rising-edge pulse, with async active-low reset. It is reused for any other SPI-domain strobes.

## Test plan
- Nominal: `z_in`=0x1234 with a `z_valid` pulse; filter model returns `kf_x`=0x1200 after 10 cycles; `tx_busy`=0 → one `kf_start`, `kf_z`=0x1234, one `tx_start`, `tx_data`=0x1200, `busy` back to 0.
- Overrun: 3 extra `z_valid` pulses while in FILT → `overrun_cnt`=3 and only the first sample is transmitted. With CNT_W=2 and 5 extra pulses → `overrun_cnt`=3 (saturated).
- Timeout: `kf_done` never asserted, TIMEOUT_CYC=16 → `timeout_err`=1 exactly 16 cycles after `kf_start`, no `tx_start`, IDLE. `clr_err` → 0. `kf_done` in the last cycle instead → no error, normal transmit.
- Back-pressure: `tx_busy`=1 held for 50 cycles at SEND → `tx_start` asserted exactly the cycle after `tx_busy` falls.
- Enable/reset: `z_valid` while `enable`=0 → no activity, `overrun_cnt` unchanged. Assert `rst_n`=0 during FILT → all outputs 0 immediately, IDLE after release.
- Bypass build (`FILTER_BYPASS_EN`): `z_in`=0xBEEF → `tx_data`=0xBEEF, `kf_start` never asserted.
